// File: rtl/channel_slot_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : channel_slot_accumulator
// Purpose  : Pipelined read-modify-write accumulator in front of a dual-port
//            channel slot RAM (2-cycle read latency, old data on same-address
//            read-during-write). Each accepted signed sample is added into its
//            slot word. A dump request adds the sample, emits the total and
//            clears the slot. After reset every slot is swept to zero before
//            samples are accepted.
// Ports    : clock, reset          - rising-edge clock, sync active-high reset
//            in_valid/in_ready     - sample handshake (no backpressure in RUN)
//            in_slot/in_data/in_dump - target slot, signed sample, dump flag
//            mem_rdaddress         - RAM read address
//            mem_wraddress/mem_wren/mem_data - RAM write port
//            mem_q                 - RAM read data
//            dump_valid/dump_slot/dump_value - one-cycle dump result
//            init_done             - zeroing sweep complete
// Options  : define CHANNEL_SLOT_ACC_SATURATE_EN to clamp sums on overflow
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module channel_slot_accumulator #(
   parameter int NUM_SLOTS  = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int IN_WIDTH   = 8,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_slot,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_dump,
   output logic [ADDR_WIDTH-1:0] mem_rdaddress,
   output logic [ADDR_WIDTH-1:0] mem_wraddress,
   output logic                  mem_wren,
   output logic [ACC_WIDTH-1:0]  mem_data,
   input  logic [ACC_WIDTH-1:0]  mem_q,
   output logic                  dump_valid,
   output logic [ADDR_WIDTH-1:0] dump_slot,
   output logic [ACC_WIDTH-1:0]  dump_value,
   output logic                  init_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_SLOT  = ADDR_WIDTH'(NUM_SLOTS - 1);
   // One extra bit so NUM_SLOTS == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0]   SLOT_LIMIT = (ADDR_WIDTH + 1)'(NUM_SLOTS);

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] sweep_cnt, sweep_cnt_nxt;

   // ------------------------------------------------------------------
   // S0: accept and issue the read
   // ------------------------------------------------------------------
   logic                  slot_ok;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] rd_hold;

   assign slot_ok = ({1'b0, in_slot} < SLOT_LIMIT);
   // Gating with reset keeps a sample from entering a pipeline that is
   // being flushed in the same cycle.
   assign accept  = in_valid & in_ready & slot_ok & ~reset;

   assign mem_rdaddress = accept ? in_slot : rd_hold;

   // Pipeline registers
   logic                  s1_valid, s2_valid;
   logic [ADDR_WIDTH-1:0] s1_slot,  s2_slot;
   logic [IN_WIDTH-1:0]   s1_data,  s2_data;
   logic                  s1_dump,  s2_dump;

   // Forwarding history: f1 = write made last cycle, f2 = two cycles ago
   logic                  f1_valid, f2_valid;
   logic [ADDR_WIDTH-1:0] f1_slot,  f2_slot;
   logic [ACC_WIDTH-1:0]  f1_value, f2_value;

   // ------------------------------------------------------------------
   // S2: add
   // ------------------------------------------------------------------
   logic [ACC_WIDTH-1:0] base;
   logic [ACC_WIDTH-1:0] s2_ext;
   logic [ACC_WIDTH-1:0] sum;
   logic [ACC_WIDTH-1:0] wr_value;
   logic                 pipe_wr;

   // Most recent write wins; the RAM cannot yet reflect either of them.
   always_comb begin
      base = mem_q;
      if (f1_valid && (f1_slot == s2_slot)) begin
         base = f1_value;
      end else if (f2_valid && (f2_slot == s2_slot)) begin
         base = f2_value;
      end
   end

   assign s2_ext = {{(ACC_WIDTH - IN_WIDTH){s2_data[IN_WIDTH-1]}}, s2_data};

`ifdef CHANNEL_SLOT_ACC_SATURATE_EN
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
   logic [ACC_WIDTH:0] wide;
   logic               overflow;

   assign wide     = {base[ACC_WIDTH-1], base} + {s2_ext[ACC_WIDTH-1], s2_ext};
   // Sign of the extended result disagreeing with the truncated sign means
   // the true sum does not fit; the extended sign gives the direction.
   assign overflow = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
   assign sum      = overflow ? (wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                              : wide[ACC_WIDTH-1:0];
`else
   assign sum = base + s2_ext;
`endif

   assign wr_value = s2_dump ? '0 : sum;
   assign pipe_wr  = (state == RUN) & s2_valid & ~reset;

   // ------------------------------------------------------------------
   // FSM next state and memory write port
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      sweep_cnt_nxt = sweep_cnt;
      mem_wren      = 1'b0;
      mem_wraddress = s2_slot;
      mem_data      = '0;
      case (state)
         INIT: begin
            mem_wren      = ~reset;
            mem_wraddress = sweep_cnt;
            sweep_cnt_nxt = sweep_cnt + 1'b1;
            if (sweep_cnt == LAST_SLOT) begin
               state_nxt     = RUN;
               sweep_cnt_nxt = '0;
            end
         end
         RUN: begin
            mem_wren = pipe_wr;
            mem_data = s2_valid ? wr_value : '0;
         end
         default: begin
            state_nxt = INIT;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= INIT;
         sweep_cnt <= '0;
         in_ready  <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         sweep_cnt <= sweep_cnt_nxt;
         in_ready  <= (state_nxt == RUN);
         init_done <= (state_nxt == RUN);
      end
   end

   // ------------------------------------------------------------------
   // Pipeline, forwarding history and dump output
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_hold    <= '0;
         s1_valid   <= 1'b0;
         s1_slot    <= '0;
         s1_data    <= '0;
         s1_dump    <= 1'b0;
         s2_valid   <= 1'b0;
         s2_slot    <= '0;
         s2_data    <= '0;
         s2_dump    <= 1'b0;
         f1_valid   <= 1'b0;
         f1_slot    <= '0;
         f1_value   <= '0;
         f2_valid   <= 1'b0;
         f2_slot    <= '0;
         f2_value   <= '0;
         dump_valid <= 1'b0;
         dump_slot  <= '0;
         dump_value <= '0;
      end else begin
         if (accept) begin
            rd_hold <= in_slot;
         end
         s1_valid <= accept;
         s1_slot  <= in_slot;
         s1_data  <= in_data;
         s1_dump  <= in_dump;
         s2_valid <= s1_valid;
         s2_slot  <= s1_slot;
         s2_data  <= s1_data;
         s2_dump  <= s1_dump;

         f1_valid <= pipe_wr;
         f1_slot  <= s2_slot;
         f1_value <= wr_value;
         f2_valid <= f1_valid;
         f2_slot  <= f1_slot;
         f2_value <= f1_value;

         dump_valid <= pipe_wr & s2_dump;
         if (pipe_wr && s2_dump) begin
            dump_slot  <= s2_slot;
            dump_value <= sum;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_channel_slot_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_channel_slot_accumulator
// Purpose  : Directed bench for channel_slot_accumulator. Two instances: the
//            default 16-slot build and a 12-slot build used for out-of-range
//            slot handling. Each has a behavioural RAM model (registered
//            address and data, old data on read-during-write). Expected dumps
//            are queued at issue time and checked by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_channel_slot_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_valid12;
   logic [3:0]  in_slot;
   logic [7:0]  in_data;
   logic        in_dump;

   logic        in_ready,   in_ready12;
   logic [3:0]  rdaddr,     rdaddr12;
   logic [3:0]  wraddr,     wraddr12;
   logic        wren,       wren12;
   logic [23:0] wdata,      wdata12;
   logic [23:0] q16,        q12;
   logic        dump_valid, dump_valid12;
   logic [3:0]  dump_slot,  dump_slot12;
   logic [23:0] dump_value, dump_value12;
   logic        init_done,  init_done12;

   // Backdoor preload of the 16-slot RAM model
   logic        bd_en;
   logic [3:0]  bd_addr;
   logic [23:0] bd_data;

   logic [23:0] mem16 [16];
   logic [23:0] mem12 [16];
   logic [3:0]  ra16, ra12;

   int cyc;
   int checks;
   int errors;

   typedef struct {
      logic [3:0]  slot;
      logic [23:0] value;
      int          due;
   } exp_t;

   exp_t sb[$];
   exp_t sb12[$];

`ifdef CHANNEL_SLOT_ACC_SATURATE_EN
   localparam logic [23:0] EXP_POS_OVF = 24'h7FFFFF;
   localparam logic [23:0] EXP_NEG_OVF = 24'h800000;
   localparam logic [23:0] EXP_WR_OVF  = 24'h7FFFFF;
`else
   localparam logic [23:0] EXP_POS_OVF = 24'h800000;
   localparam logic [23:0] EXP_NEG_OVF = 24'h7FFFFF;
   localparam logic [23:0] EXP_WR_OVF  = 24'h80006F;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (wren) mem16[wraddr] <= wdata;
      if (bd_en) mem16[bd_addr] <= bd_data;
      ra16 <= rdaddr;
      q16  <= mem16[ra16];
      if (wren12) mem12[wraddr12] <= wdata12;
      ra12 <= rdaddr12;
      q12  <= mem12[ra12];
   end

   channel_slot_accumulator dut (
      .clock         (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_slot       (in_slot),
      .in_data       (in_data),
      .in_dump       (in_dump),
      .mem_rdaddress (rdaddr),
      .mem_wraddress (wraddr),
      .mem_wren      (wren),
      .mem_data      (wdata),
      .mem_q         (q16),
      .dump_valid    (dump_valid),
      .dump_slot     (dump_slot),
      .dump_value    (dump_value),
      .init_done     (init_done)
   );

   channel_slot_accumulator #(.NUM_SLOTS(12)) dut12 (
      .clock         (clk),
      .reset         (reset),
      .in_valid      (in_valid12),
      .in_ready      (in_ready12),
      .in_slot       (in_slot),
      .in_data       (in_data),
      .in_dump       (in_dump),
      .mem_rdaddress (rdaddr12),
      .mem_wraddress (wraddr12),
      .mem_wren      (wren12),
      .mem_data      (wdata12),
      .mem_q         (q12),
      .dump_valid    (dump_valid12),
      .dump_slot     (dump_slot12),
      .dump_value    (dump_value12),
      .init_done     (init_done12)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid   = 1'b0;
      in_valid12 = 1'b0;
      in_dump    = 1'b0;
      repeat (n) step();
   endtask

   // Issue one sample to the 16-slot instance; a dump queues its expected total.
   task automatic issue(input int slot, input int data, input bit dump, input logic [23:0] exp);
      in_valid = 1'b1;
      in_slot  = 4'(slot);
      in_data  = 8'(data);
      in_dump  = dump;
      if (dump) sb.push_back('{4'(slot), exp, cyc + 3});
      step();
      in_valid = 1'b0;
      in_dump  = 1'b0;
   endtask

   task automatic issue12(input int slot, input int data, input bit dump, input logic [23:0] exp);
      in_valid12 = 1'b1;
      in_slot    = 4'(slot);
      in_data    = 8'(data);
      in_dump    = dump;
      if (dump) sb12.push_back('{4'(slot), exp, cyc + 3});
      step();
      in_valid12 = 1'b0;
      in_dump    = 1'b0;
   endtask

   task automatic preload(input int slot, input logic [23:0] value);
      bd_en   = 1'b1;
      bd_addr = 4'(slot);
      bd_data = value;
      step();
      bd_en   = 1'b0;
   endtask

   // Called in the first cycle after reset is released.
   task automatic sweep_check();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("sweep_wren",    32'(wren),     32'd1);
         chk("sweep_wraddr",  32'(wraddr),   32'(i));
         chk("sweep_data",    32'(wdata),    32'd0);
         chk("sweep_inready", 32'(in_ready), 32'd0);
         if (i < 12) begin
            chk("sweep12_wren",   32'(wren12),   32'd1);
            chk("sweep12_wraddr", 32'(wraddr12), 32'(i));
         end
         step();
         if (i == 15) in_valid = 1'b0;
      end
      @(negedge clk);
      chk("init_done",   32'(init_done),   32'd1);
      chk("in_ready",    32'(in_ready),    32'd1);
      chk("init_done12", 32'(init_done12), 32'd1);
      step();
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && dump_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL dump16 unexpected: slot=%0d value=%h cycle=%0d", dump_slot, dump_value, cyc);
            end else begin
               e = sb.pop_front();
               if (dump_slot !== e.slot || dump_value !== e.value || cyc != e.due) begin
                  errors++;
                  $display("FAIL dump16 actual slot=%0d value=%h cycle=%0d required slot=%0d value=%h cycle=%0d",
                           dump_slot, dump_value, cyc, e.slot, e.value, e.due);
               end
            end
         end
         if (!reset && dump_valid12) begin
            checks++;
            if (sb12.size() == 0) begin
               errors++;
               $display("FAIL dump12 unexpected: slot=%0d value=%h cycle=%0d", dump_slot12, dump_value12, cyc);
            end else begin
               e = sb12.pop_front();
               if (dump_slot12 !== e.slot || dump_value12 !== e.value || cyc != e.due) begin
                  errors++;
                  $display("FAIL dump12 actual slot=%0d value=%h cycle=%0d required slot=%0d value=%h cycle=%0d",
                           dump_slot12, dump_value12, cyc, e.slot, e.value, e.due);
               end
            end
         end
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_valid12 = 1'b0;
      in_slot    = '0;
      in_data    = '0;
      in_dump    = 1'b0;
      bd_en      = 1'b0;
      bd_addr    = '0;
      bd_data    = '0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) step();
      @(negedge clk);
      chk("rst_in_ready",   32'(in_ready),   32'd0);
      chk("rst_init_done",  32'(init_done),  32'd0);
      chk("rst_wren",       32'(wren),       32'd0);
      chk("rst_rdaddr",     32'(rdaddr),     32'd0);
      chk("rst_wraddr",     32'(wraddr),     32'd0);
      chk("rst_wdata",      32'(wdata),      32'd0);
      chk("rst_dump_valid", 32'(dump_valid), 32'd0);
      chk("rst_dump_slot",  32'(dump_slot),  32'd0);
      chk("rst_dump_value", 32'(dump_value), 32'd0);
      step();

      // Release reset with a sample held on the inputs through the sweep
      reset    = 1'b0;
      in_valid = 1'b1;
      in_slot  = 4'd5;
      in_data  = 8'd9;
      sweep_check();

      // Held sample must not have reached slot 5
      issue(5, 0, 1'b1, 24'd0);
      idle(3);

      // Forwarding at distances 1 and 2
      issue(3, 5, 1'b0, '0);
      issue(3, 7, 1'b0, '0);
      issue(3, -2, 1'b0, '0);
      issue(3, 1, 1'b1, 24'd11);
      idle(3);
      issue(3, 0, 1'b1, 24'd0);
      idle(3);

      // Interleaved slots
      issue(1, 10, 1'b0, '0);
      issue(2, 20, 1'b0, '0);
      issue(1, 30, 1'b0, '0);
      issue(2, 40, 1'b0, '0);
      issue(1, 0, 1'b1, 24'd40);
      issue(2, 0, 1'b1, 24'd60);
      idle(3);

      // Negative accumulation: -100 -100 -28 = -228
      issue(5, -100, 1'b0, '0);
      issue(5, -100, 1'b0, '0);
      issue(5, -28, 1'b1, 24'hFFFF1C);
      idle(3);

      // Value comes back through the RAM rather than forwarding
      issue(6, 50, 1'b0, '0);
      idle(4);
      issue(6, 25, 1'b1, 24'd75);
      idle(3);

      // Overflow boundaries
      preload(0, 24'h7FFFFF);
      idle(2);
      issue(0, 1, 1'b1, EXP_POS_OVF);
      idle(3);
      preload(0, 24'h800000);
      idle(2);
      issue(0, -1, 1'b1, EXP_NEG_OVF);
      idle(3);
      preload(7, 24'h7FFFF0);
      idle(2);
      issue(7, 127, 1'b0, '0);
      idle(3);
      issue(7, 0, 1'b1, EXP_WR_OVF);
      idle(3);

      // Out-of-range slot on the 12-slot instance
      issue12(15, 9, 1'b1, '0);
      sb12.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("oor_wren12", 32'(wren12), 32'd0);
         step();
      end
      issue12(11, 7, 1'b1, 24'd7);
      idle(4);

      // Reset while a dump sits in S1
      issue(4, 33, 1'b0, '0);
      issue(9, 44, 1'b0, '0);
      idle(3);
      in_valid = 1'b1;
      in_slot  = 4'd4;
      in_data  = 8'd1;
      in_dump  = 1'b1;
      step();
      in_valid = 1'b0;
      in_dump  = 1'b0;
      reset    = 1'b1;
      step();
      reset    = 1'b0;
      sweep_check();
      for (int s = 0; s < 16; s++) issue(s, 0, 1'b1, 24'd0);
      idle(5);

      chk("sb16_drained", 32'(sb.size()),   32'd0);
      chk("sb12_drained", 32'(sb12.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/channel_slot_accumulator.md
Name: channel_slot_accumulator

Overview:
- Pipelined read-modify-write controller in front of the channel slot memory (dual-port RAM; registered read address and registered read data, so 2-cycle read latency; old data returned on same-address read-during-write).
- Accepts a stream of per-slot signed samples from the upstream correlator mux and accumulates each sample into its slot's memory word.
- On request, it dumps a slot: emits the final accumulated value downstream and zeroes the slot.
- Handles back-to-back same-slot hazards by forwarding, and zero-initialises every slot after reset.

Parameters:
NUM_SLOTS, 16, number of channel slots (memory depth)
ADDR_WIDTH, 4, slot index width; must satisfy 2**ADDR_WIDTH >= NUM_SLOTS
IN_WIDTH, 8, signed sample width
ACC_WIDTH, 24, signed accumulator/memory word width; must be greater than IN_WIDTH

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  sample present this cycle
in_ready  out  1  high when the block accepts samples
in_slot  in  ADDR_WIDTH  target slot
in_data  in  IN_WIDTH  signed sample
in_dump  in  1  add the sample, output the total, then clear the slot
mem_rdaddress  out  ADDR_WIDTH  memory read address
mem_wraddress  out  ADDR_WIDTH  memory write address
mem_wren  out  1  memory write enable
mem_data  out  ACC_WIDTH  memory write data
mem_q  in  ACC_WIDTH  memory read data (valid 2 cycles after mem_rdaddress)
dump_valid  out  1  one-cycle strobe
dump_slot  out  ADDR_WIDTH  slot that was dumped
dump_value  out  ACC_WIDTH  final accumulated value
init_done  out  1  high once the zeroing sweep is complete

Behaviour:
- Reset values: in_ready=0, init_done=0, mem_wren=0, mem_rdaddress=0, mem_wraddress=0, mem_data=0, dump_valid=0, dump_slot=0, dump_value=0. All pipeline valid bits are cleared.
- FSM states are INIT and RUN. Reset asserted in any cycle, including mid-operation, forces INIT with the sweep counter at 0; in-flight operations are discarded and never written back.
- INIT:
  - Each cycle: mem_wren=1, mem_wraddress=counter, mem_data=0; the counter then increments.
  - After the write to slot NUM_SLOTS-1, the next state is RUN. The sweep takes exactly NUM_SLOTS cycles.
  - in_ready=0 throughout; any in_valid during INIT is ignored.
- RUN: in_ready=1 and init_done=1, both registered, from the first RUN cycle. There is no backpressure: one sample is accepted every cycle.
- Pipeline (sample accepted in cycle t):
  - S0 (cycle t): mem_rdaddress=in_slot combinationally; slot, data and dump flag are registered.
  - S1 (t+1): wait for memory.
  - S2 (t+2): base = forwarded value or mem_q; sum = base + sign-extended in_data. Drive mem_wren=1, mem_wraddress=slot, mem_data = (dump ? 0 : sum).
  - Output (t+3): if dump, dump_valid=1, dump_slot=slot, dump_value=sum.
- Forwarding:
  - The S2 base comes from the S2 write made in cycle t+1 if it was to the same slot; else from the write made in t+2-2 if same slot; else mem_q. The most recent write wins.
  - Forwarded values are the written values (0 after a dump).
- Arithmetic: two's-complement, ACC_WIDTH bits; overflow wraps (unless the optional feature is enabled).
- mem_wren=0 in RUN cycles where S2 is empty. mem_rdaddress holds its last value when in_valid=0.
- Out-of-range slot (in_slot >= NUM_SLOTS) is dropped at S0: no read, no write, no dump.
- Simultaneous in_valid with the INIT→RUN transition cycle: ignored, since in_ready is still 0.

Optional Feature:
- Macro: CHANNEL_SLOT_ACC_SATURATE_EN.
- Defined: sum clamps to the max/min signed ACC_WIDTH value on overflow; the clamped value is both written and dumped.
- Undefined: wrap-around as above. No ports change.

Test Plan:
- Reset, then hold in_valid=1 → in_ready stays 0 for 16 cycles; mem_wren=1 with mem_wraddress 0..15 and mem_data 0; init_done rises on cycle 17; no writes come from the held inputs.
- Slot 3 gets +5, +7, -2 in consecutive cycles, then a dump with +1 → exactly one dump strobe: dump_slot=3, dump_value=11, 3 cycles after the dump input; slot 3 then reads 0. This exercises forwarding at distances 1 and 2.
- Interleave slots 1, 2, 1, 2 with data 10, 20, 30, 40, then dump both with 0 → dump_value 40 for slot 1 and 60 for slot 2.
- Accumulate 0x7FFFFF + 1 in slot 0 and dump → 0x800000 with the macro undefined; 0x7FFFFF with CHANNEL_SLOT_ACC_SATURATE_EN defined.
- Assert reset mid-stream while a dump is in S1 → no dump_valid; INIT sweep restarts at slot 0; all slots dump 0 afterwards.
- in_slot=15 with NUM_SLOTS=12 → mem_wren never asserts for it and no dump is produced.
